// File: rtl/facelet_overlay_renderer_if.sv
// Bus bundle for the facelet overlay renderer: facelet write channel,
// face status, and the pixel-in / pixel-out stream.
//
// Handshake: a write transfers on a rising clock edge where wr_valid and
// wr_ready are both high; wr_valid/wr_idx/wr_code must be stable while
// wr_valid is high and unaccepted. The pixel stream has no backpressure:
// every pix_valid cycle produces exactly one rgb_valid cycle two clocks later.
interface facelet_overlay_renderer_if;
  logic        wr_valid;
  logic [3:0]  wr_idx;
  logic [2:0]  wr_code;
  logic        wr_ready;
  logic        wr_err;
  logic        clear;
  logic        face_complete;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [29:0] bg_rgb;
  logic [29:0] rgb_out;
  logic        rgb_valid;
  logic        wr_state_dbg;   // 0 = FILLING, 1 = COMPLETE

  modport master (
    output wr_valid, wr_idx, wr_code, clear, pix_valid, pix_x, pix_y, bg_rgb,
    input  wr_ready, wr_err, face_complete, rgb_out, rgb_valid, wr_state_dbg
  );

  modport slave (
    input  wr_valid, wr_idx, wr_code, clear, pix_valid, pix_x, pix_y, bg_rgb,
    output wr_ready, wr_err, face_complete, rgb_out, rgb_valid, wr_state_dbg
  );
endinterface

// File: rtl/facelet_overlay_renderer.sv
// Renders a 3x3 grid of classified sticker colour codes as a 30-bit RGB
// overlay on top of the camera image. Codes arrive over a valid/ready write
// channel; pixels flow through a fixed 2-stage pipeline.
module facelet_overlay_renderer #(
  parameter int unsigned GRID_X0 = 200,
  parameter int unsigned GRID_Y0 = 140,
  parameter int unsigned CELL    = 80,
  parameter int unsigned BORDER  = 4
) (
  input logic                 Clk,
  input logic                 Reset,
  facelet_overlay_renderer_if.slave bus
);

  // Grid geometry in 11 bits so GRID_X0 + 3*CELL cannot wrap.
  localparam logic [10:0] X_C0  = 11'(GRID_X0);
  localparam logic [10:0] X_C1  = 11'(GRID_X0 + CELL);
  localparam logic [10:0] X_C2  = 11'(GRID_X0 + 2 * CELL);
  localparam logic [10:0] X_C3  = 11'(GRID_X0 + 3 * CELL);
  localparam logic [10:0] Y_C0  = 11'(GRID_Y0);
  localparam logic [10:0] Y_C1  = 11'(GRID_Y0 + CELL);
  localparam logic [10:0] Y_C2  = 11'(GRID_Y0 + 2 * CELL);
  localparam logic [10:0] Y_C3  = 11'(GRID_Y0 + 3 * CELL);
  localparam logic [10:0] B_LO  = 11'(BORDER);
  localparam logic [10:0] B_HI  = 11'(CELL - BORDER);

  typedef enum logic {
    FILLING  = 1'b0,
    COMPLETE = 1'b1
  } wr_state_e;

  // Colour code to display colour.
  function automatic logic [29:0] palette(input logic [2:0] code);
    logic [29:0] rgb;
    case (code)
      3'd0:    rgb = 30'h10040100;
      3'd1:    rgb = 30'h3FF00000;
      3'd2:    rgb = 30'h000FFC00;
      3'd3:    rgb = 30'h000003FF;
      3'd4:    rgb = 30'h3FFFFC00;
      3'd5:    rgb = 30'h3FFFFFFF;
      3'd6:    rgb = 30'h3FFE9400;
      default: rgb = 30'h0;
    endcase
    return rgb;
  endfunction

  // ---------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------
  wr_state_e   state_q, state_d;
  logic [8:0]  mask_q, mask_d;
  logic [2:0]  code_q [9];
  logic        wr_err_q, wr_err_d;
  logic        wr_en;
  logic        xfer;
  logic        idx_ok;

  assign xfer   = bus.wr_valid && bus.wr_ready;
  assign idx_ok = (bus.wr_idx <= 4'd8);

  // Next-state: clear dominates any write; completion when the mask fills.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    wr_err_d = 1'b0;
    wr_en    = 1'b0;
    if (bus.clear) begin
      state_d = FILLING;
      mask_d  = '0;
    end else if (xfer) begin
      if (idx_ok) begin
        wr_en  = 1'b1;
        mask_d = mask_q | (9'b1 << bus.wr_idx);
        if (&mask_d) begin
          state_d = COMPLETE;
        end
      end else begin
        wr_err_d = 1'b1;
      end
    end
  end

  // State, mask and error-pulse registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= FILLING;
      mask_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Facelet code storage; wiped by reset or clear.
  always_ff @(posedge Clk) begin
    if (Reset || bus.clear) begin
      for (int i = 0; i < 9; i++) begin
        code_q[i] <= '0;
      end
    end else if (wr_en) begin
      code_q[bus.wr_idx] <= bus.wr_code;
    end
  end

  assign bus.wr_ready      = (state_q == FILLING);
  assign bus.face_complete = (state_q == COMPLETE);
  assign bus.wr_err        = wr_err_q;
  assign bus.wr_state_dbg  = state_q;

  // ---------------------------------------------------------------------
  // Pixel pipeline, stage 1: locate the pixel within the grid
  // ---------------------------------------------------------------------
  logic [10:0] x11, y11;
  logic [10:0] ox, oy;
  logic [1:0]  col, row;
  logic        in_grid;
  logic        border;

  assign x11 = {1'b0, bus.pix_x};
  assign y11 = {1'b0, bus.pix_y};

  // Cell column/row and in-cell offsets via boundary compares (no divider).
  always_comb begin
    col = 2'd0;
    row = 2'd0;
    ox  = x11 - X_C0;
    oy  = y11 - Y_C0;
    if (x11 >= X_C2) begin
      col = 2'd2;
      ox  = x11 - X_C2;
    end else if (x11 >= X_C1) begin
      col = 2'd1;
      ox  = x11 - X_C1;
    end
    if (y11 >= Y_C2) begin
      row = 2'd2;
      oy  = y11 - Y_C2;
    end else if (y11 >= Y_C1) begin
      row = 2'd1;
      oy  = y11 - Y_C1;
    end
  end

  assign in_grid = (x11 >= X_C0) && (x11 < X_C3) && (y11 >= Y_C0) && (y11 < Y_C3);
  assign border  = (ox < B_LO) || (ox >= B_HI) || (oy < B_LO) || (oy >= B_HI);

  logic        s1_valid_q;
  logic        s1_in_grid_q;
  logic        s1_border_q;
  logic [1:0]  s1_col_q;
  logic [1:0]  s1_row_q;
  logic [29:0] s1_bg_q;

  // Stage 1 registers; payload only advances on a valid pixel.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q   <= 1'b0;
      s1_in_grid_q <= 1'b0;
      s1_border_q  <= 1'b0;
      s1_col_q     <= '0;
      s1_row_q     <= '0;
      s1_bg_q      <= '0;
    end else begin
      s1_valid_q <= bus.pix_valid;
      if (bus.pix_valid) begin
        s1_in_grid_q <= in_grid;
        s1_border_q  <= border;
        s1_col_q     <= col;
        s1_row_q     <= row;
        s1_bg_q      <= bus.bg_rgb;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pixel pipeline, stage 2: choose background, border or facelet colour
  // ---------------------------------------------------------------------
  logic [3:0]  s2_idx;
  logic [29:0] s2_rgb;

  assign s2_idx = ({2'b00, s1_row_q} * 4'd3) + {2'b00, s1_col_q};

  // Codes are read here so a write landing on the same edge a pixel is
  // sampled is already visible to that pixel.
  always_comb begin
    s2_rgb = s1_bg_q;
    if (s1_in_grid_q) begin
      if (s1_border_q) begin
        s2_rgb = 30'h0;
      end else begin
        s2_rgb = palette(code_q[s2_idx]);
      end
    end
  end

  logic        rgb_valid_q;
  logic [29:0] rgb_q;

  // Output registers; rgb_out holds between valid pixels.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rgb_valid_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      rgb_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        rgb_q <= s2_rgb;
      end
    end
  end

  assign bus.rgb_out   = rgb_q;
  assign bus.rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_facelet_overlay_renderer.sv
// Self-checking bench for facelet_overlay_renderer: directed steps from the
// test plan followed by randomized traffic, all checked against a
// cycle-level behavioural model of the face store and pixel rendering.
module tb_facelet_overlay_renderer;

  localparam int GX0  = 200;
  localparam int GY0  = 140;
  localparam int CELL = 80;
  localparam int BRD  = 4;

  // Clock and reset
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  facelet_overlay_renderer_if bus();

  facelet_overlay_renderer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Scoreboard / model state
  int          checks   = 0;
  int          failures = 0;
  int          m_code [9];
  bit [8:0]    m_mask;
  bit          m_complete;
  bit          m_err;
  bit          pend_v;
  logic [29:0] pend_rgb;
  logic [29:0] exp_out;

  function automatic logic [29:0] pal(input int code);
    case (code)
      0:       return 30'h10040100;
      1:       return 30'h3FF00000;
      2:       return 30'h000FFC00;
      3:       return 30'h000003FF;
      4:       return 30'h3FFFFC00;
      5:       return 30'h3FFFFFFF;
      6:       return 30'h3FFE9400;
      default: return 30'h0;
    endcase
  endfunction

  // Expected overlay colour from geometry with plain division/modulo.
  function automatic logic [29:0] ref_pix(input int x, input int y, input logic [29:0] bg);
    int cx, cy, ox, oy;
    if (x < GX0 || x >= GX0 + 3 * CELL || y < GY0 || y >= GY0 + 3 * CELL) return bg;
    cx = (x - GX0) / CELL;
    cy = (y - GY0) / CELL;
    ox = (x - GX0) % CELL;
    oy = (y - GY0) % CELL;
    if (ox < BRD || ox >= CELL - BRD || oy < BRD || oy >= CELL - BRD) return 30'h0;
    return pal(m_code[cy * 3 + cx]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_wipe();
    for (int i = 0; i < 9; i++) m_code[i] = 0;
    m_mask     = '0;
    m_complete = 1'b0;
  endtask

  // Driver: one clock cycle of stimulus, then model update and checks.
  task automatic step(input bit rst, input bit wv, input int idx, input int code,
                      input bit clr, input bit pv, input int x, input int y,
                      input logic [29:0] bg);
    bit xfer;
    @(negedge Clk);
    Reset         = rst;
    bus.wr_valid  = wv;
    bus.wr_idx    = 4'(idx);
    bus.wr_code   = 3'(code);
    bus.clear     = clr;
    bus.pix_valid = pv;
    bus.pix_x     = 10'(x);
    bus.pix_y     = 10'(y);
    bus.bg_rgb    = bg;
    @(posedge Clk);
    #1;
    m_err = 1'b0;
    if (rst) begin
      model_wipe();
      pend_v  = 1'b0;
      exp_out = '0;
    end else begin
      xfer = wv && !m_complete;
      if (clr) begin
        model_wipe();
      end else if (xfer) begin
        if (idx <= 8) begin
          m_code[idx] = code;
          m_mask[idx] = 1'b1;
          if (m_mask == 9'h1FF) m_complete = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    chk("wr_err", bus.wr_err, m_err);
    chk("face_complete", bus.face_complete, m_complete);
    chk("wr_ready", bus.wr_ready, !m_complete);
    chk("rgb_valid", bus.rgb_valid, pend_v);
    if (pend_v) exp_out = pend_rgb;
    chk("rgb_out", bus.rgb_out, exp_out);
    pend_v = pv && !rst;
    if (pend_v) pend_rgb = ref_pix(x, y, bg);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 30'h0);
  endtask

  task automatic pix(input int x, input int y, input logic [29:0] bg);
    step(0, 0, 0, 0, 0, 1, x, y, bg);
  endtask

  task automatic wr(input int idx, input int code);
    step(0, 1, idx, code, 0, 0, 0, 0, 30'h0);
  endtask

  int          px [6] = '{320, 280, 283, 356, 284, 355};
  logic [29:0] pe [6] = '{30'h3FF00000, 30'h0, 30'h0, 30'h0, 30'h3FF00000, 30'h3FF00000};
  int          fill_codes [9] = '{1, 2, 3, 4, 5, 6, 1, 2, 3};

  initial begin
    Reset = 1'b1;
    bus.wr_valid = 0; bus.wr_idx = 0; bus.wr_code = 0; bus.clear = 0;
    bus.pix_valid = 0; bus.pix_x = 0; bus.pix_y = 0; bus.bg_rgb = 0;
    model_wipe();
    pend_v = 0; pend_rgb = 0; exp_out = 0; m_err = 0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 30'h0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 30'h0);
    chk("reset_rgb_out", bus.rgb_out, 30'h0);
    chk("reset_wr_ready", bus.wr_ready, 1'b1);

    // Unset cell renders gray, outside the grid passes the background
    pix(320, 260, 30'h12345678);
    pix(100, 100, 30'h12345678);
    chk("unset_gray", bus.rgb_out, 30'h10040100);
    idle();
    chk("bg_pass", bus.rgb_out, 30'h12345678);

    // Centre cell red with border pixels black
    wr(4, 1);
    for (int i = 0; i < 6; i++) begin
      pix(px[i], 260, 30'h2AAAAAAA);
      if (i > 0) chk("border_scan", bus.rgb_out, pe[i-1]);
    end
    idle();
    chk("border_scan_last", bus.rgb_out, pe[5]);

    // Fill the whole face, then confirm it is frozen
    for (int i = 0; i < 9; i++) begin
      wr(i, fill_codes[i]);
      if (i == 7) chk("not_complete_8", bus.face_complete, 1'b0);
    end
    chk("complete_after_9", bus.face_complete, 1'b1);
    chk("ready_drops", bus.wr_ready, 1'b0);
    wr(0, 5);
    pix(240, 180, 30'h0);
    idle();
    chk("frozen_idx0_red", bus.rgb_out, 30'h3FF00000);

    // Clear wins over a simultaneous write
    step(0, 1, 2, 6, 1, 0, 0, 0, 30'h0);
    chk("clear_no_err", bus.wr_err, 1'b0);
    chk("clear_ready", bus.wr_ready, 1'b1);
    pix(400, 180, 30'h0);
    idle();
    chk("clear_gray", bus.rgb_out, 30'h10040100);

    // Out-of-range index
    wr(9, 3);
    chk("idx9_err", bus.wr_err, 1'b1);
    idle();
    chk("idx9_err_once", bus.wr_err, 1'b0);
    chk("idx9_not_complete", bus.face_complete, 1'b0);

    // Write and pixel on the same edge
    step(0, 1, 4, 6, 0, 1, 320, 260, 30'h0);
    idle();
    chk("same_edge_orange", bus.rgb_out, 30'h3FFE9400);

    // Reset with two pixels in flight
    pix(320, 260, 30'h1);
    pix(100, 100, 30'h2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 30'h0);
    chk("flush_valid", bus.rgb_valid, 1'b0);
    chk("flush_rgb", bus.rgb_out, 30'h0);
    idle();
    chk("flush_valid_late", bus.rgb_valid, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 1) == 1),
           $urandom_range(0, 10),
           $urandom_range(0, 7),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 3) != 0),
           $urandom_range(150, 500),
           $urandom_range(100, 420),
           30'($urandom));
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
